// File: rtl/ofm_quant_pack.sv
// ofm_quant_pack: requantizes the two CONV_ACC output streams to int8, packs
// PACK bytes per lane into 64-bit words and queues them in a small FIFO.
// CONV_ACC cannot be stalled, so a word that finds no FIFO slot is dropped and
// flagged on the sticky overflow output.
// Build option: define OFM_QUANT_STATS_EN to add the sat_cnt/word_cnt counters.

// Per-lane datapath: ReLU + rounding shift + saturation register, then packer.
module ofm_quant_lane #(
    parameter int IN_W    = 25,
    parameter int PACK    = 8,
    parameter int SHIFT_W = 5
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                clr,
    input  logic                in_v,
    input  logic [IN_W-1:0]     in_data,
    input  logic [SHIFT_W-1:0]  shift,
    input  logic                relu,
    input  logic                flush,
    output logic                wr,
    output logic [8*PACK-1:0]   word
`ifdef OFM_QUANT_STATS_EN
    ,
    output logic                sat
`endif
);
    localparam int CW = $clog2(PACK);

    logic signed [IN_W:0]  x, rnd, sum, y;
    logic [7:0]            qb;
    logic                  qs;
    logic                  q_v, q_s;
    logic [7:0]            q_b;
    logic [CW-1:0]         cnt;
    logic [PACK-1:0][7:0]  bytes, full;
    logic                  last;

    // Requantize one sample: optional ReLU, round-half-up shift, clip to int8
    always_comb begin
        x = {in_data[IN_W-1], in_data};
        if (relu && x < 0) x = '0;
        rnd = '0;
        if (shift != '0) rnd = (IN_W+1)'(1) << (shift - SHIFT_W'(1));
        sum = x + rnd;
        y   = sum >>> shift;
        qs  = 1'b0;
        qb  = y[7:0];
        if (y > 127) begin
            qb = 8'h7f;
            qs = 1'b1;
        end else if (y < -128) begin
            qb = 8'h80;
            qs = 1'b1;
        end
    end

    // Word assembly: the completing byte is merged so the word leaves the same edge
    always_comb begin
        last      = (cnt == CW'(PACK-1));
        full      = bytes;
        full[cnt] = q_b;
        wr        = flush ? (cnt != '0) : (q_v && last);
        word      = flush ? bytes : full;
    end

    // Stage 1 result register and packer byte/count state
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            q_v   <= 1'b0;
            q_b   <= '0;
            q_s   <= 1'b0;
            bytes <= '0;
            cnt   <= '0;
        end else if (clr) begin
            q_v   <= 1'b0;
            q_b   <= '0;
            q_s   <= 1'b0;
            bytes <= '0;
            cnt   <= '0;
        end else begin
            q_v <= in_v;
            q_b <= qb;
            q_s <= qs;
            if (flush) begin
                bytes <= '0;
                cnt   <= '0;
            end else if (q_v) begin
                if (last) begin
                    bytes <= '0;
                    cnt   <= '0;
                end else begin
                    bytes[cnt] <= q_b;
                    cnt        <= cnt + CW'(1);
                end
            end
        end
    end

`ifdef OFM_QUANT_STATS_EN
    assign sat = q_v && q_s;
`endif
endmodule

module ofm_quant_pack #(
    parameter int IN_W       = 25,
    parameter int PACK       = 8,
    parameter int FIFO_DEPTH = 8,
    parameter int SHIFT_W    = 5
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    input  logic [SHIFT_W-1:0]  cfg_shift,
    input  logic                cfg_relu,
    input  logic [IN_W-1:0]     ofm_port0,
    input  logic [IN_W-1:0]     ofm_port1,
    input  logic                ofm_port0_v,
    input  logic                ofm_port1_v,
    input  logic                end_conv,
    output logic [8*PACK-1:0]   out_data,
    output logic                out_row,
    output logic                out_valid,
    input  logic                out_ready,
    output logic                overflow,
    output logic                done
`ifdef OFM_QUANT_STATS_EN
    ,
    output logic [31:0]         sat_cnt,
    output logic [31:0]         word_cnt
`endif
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int DW = 8 * PACK;

    typedef enum logic [2:0] {S_IDLE, S_RUN, S_ENDW, S_FLUSH, S_DRAIN} state_t;

    state_t                   state, state_nxt;
    logic                     done_nxt;
    logic [SHIFT_W-1:0]       shift_q;
    logic                     relu_q;
    logic                     flush;
    logic [1:0]               in_v, wr;
    logic [1:0][IN_W-1:0]     in_d;
    logic [1:0][DW-1:0]       word;

    logic [AW:0]              wptr, rptr, used, free;
    logic [DW:0]              mem [FIFO_DEPTH];
    logic                     empty, pop, acc0, acc1, drop;
    logic [AW-1:0]            widx1;

    // Valids are only taken in RUN; start discards anything arriving with it
    assign in_v[0] = ofm_port0_v && (state == S_RUN) && !start;
    assign in_v[1] = ofm_port1_v && (state == S_RUN) && !start;
    assign in_d[0] = ofm_port0;
    assign in_d[1] = ofm_port1;
    assign flush   = (state == S_FLUSH) && !start;

`ifdef OFM_QUANT_STATS_EN
    logic [1:0] sat;
`endif

    for (genvar g = 0; g < 2; g++) begin : g_lane
        ofm_quant_lane #(.IN_W(IN_W), .PACK(PACK), .SHIFT_W(SHIFT_W)) u_lane (
            .clk     (clk),
            .rst     (rst),
            .clr     (start),
            .in_v    (in_v[g]),
            .in_data (in_d[g]),
            .shift   (shift_q),
            .relu    (relu_q),
            .flush   (flush),
            .wr      (wr[g]),
            .word    (word[g])
`ifdef OFM_QUANT_STATS_EN
            ,
            .sat     (sat[g])
`endif
        );
    end

    // FIFO slot accounting: a pop frees its slot before this cycle's pushes
    always_comb begin
        used  = wptr - rptr;
        empty = (used == '0);
        pop   = !empty && out_ready;
        free  = (AW+1)'(FIFO_DEPTH) - used + {{AW{1'b0}}, pop};
        acc0  = wr[0] && !start && (free != '0);
        acc1  = wr[1] && !start && (free > {{AW{1'b0}}, acc0});
        drop  = !start && ((wr[0] && !acc0) || (wr[1] && !acc1));
        widx1 = wptr[AW-1:0] + AW'(acc0);
    end

    assign out_valid = !empty;
    assign out_data  = out_valid ? mem[rptr[AW-1:0]][DW-1:0] : '0;
    assign out_row   = out_valid ? mem[rptr[AW-1:0]][DW]     : 1'b0;

    // FIFO storage; port0 word takes the lower slot so it pops first
    always_ff @(posedge clk) begin
        if (acc0) mem[wptr[AW-1:0]] <= {1'b0, word[0]};
        if (acc1) mem[widx1]        <= {1'b1, word[1]};
    end

    // FIFO pointers, sticky overflow and latched configuration
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wptr     <= '0;
            rptr     <= '0;
            overflow <= 1'b0;
            shift_q  <= '0;
            relu_q   <= 1'b0;
        end else if (start) begin
            wptr     <= '0;
            rptr     <= '0;
            overflow <= 1'b0;
            shift_q  <= cfg_shift;
            relu_q   <= cfg_relu;
        end else begin
            wptr     <= wptr + (AW+1)'(acc0) + (AW+1)'(acc1);
            rptr     <= rptr + (AW+1)'(pop);
            overflow <= overflow || drop;
        end
    end

    // State register and registered done pulse
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= S_IDLE;
            done  <= 1'b0;
        end else begin
            state <= state_nxt;
            done  <= done_nxt;
        end
    end

    // Next state: ENDW gives stage 1 and the packer time to absorb the last sample
    always_comb begin
        state_nxt = state;
        done_nxt  = 1'b0;
        if (start) begin
            state_nxt = S_RUN;
        end else begin
            case (state)
                S_RUN:   if (end_conv) state_nxt = S_ENDW;
                S_ENDW:  state_nxt = S_FLUSH;
                S_FLUSH: state_nxt = S_DRAIN;
                S_DRAIN: if (empty) begin
                    state_nxt = S_IDLE;
                    done_nxt  = 1'b1;
                end
                default: state_nxt = state;
            endcase
        end
    end

`ifdef OFM_QUANT_STATS_EN
    logic [32:0] sat_sum, word_sum;

    // Saturating statistics counters
    always_comb begin
        sat_sum  = {1'b0, sat_cnt} + 33'(sat[0]) + 33'(sat[1]);
        word_sum = {1'b0, word_cnt} + 33'(pop);
    end

    // Counter registers, cleared by start and held at all-ones
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sat_cnt  <= '0;
            word_cnt <= '0;
        end else if (start) begin
            sat_cnt  <= '0;
            word_cnt <= '0;
        end else begin
            sat_cnt  <= sat_sum[32]  ? '1 : sat_sum[31:0];
            word_cnt <= word_sum[32] ? '1 : word_sum[31:0];
        end
    end
`endif
endmodule

// File: tb/tb_ofm_quant_pack.sv
// Directed bench for ofm_quant_pack with hand-computed expected words.
module tb_ofm_quant_pack;
    localparam int DEPTH = 8;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic [4:0]  cfg_shift = '0;
    logic        cfg_relu = 1'b0;
    logic [24:0] ofm_port0 = '0, ofm_port1 = '0;
    logic        ofm_port0_v = 1'b0, ofm_port1_v = 1'b0;
    logic        end_conv = 1'b0;
    logic [63:0] out_data;
    logic        out_row, out_valid, overflow, done;
    logic        out_ready = 1'b0;
`ifdef OFM_QUANT_STATS_EN
    logic [31:0] sat_cnt, word_cnt;
`endif

    int n_cmp = 0;
    int n_err = 0;

    ofm_quant_pack #(.IN_W(25), .PACK(8), .FIFO_DEPTH(DEPTH), .SHIFT_W(5)) dut (
        .clk(clk), .rst(rst), .start(start), .cfg_shift(cfg_shift), .cfg_relu(cfg_relu),
        .ofm_port0(ofm_port0), .ofm_port1(ofm_port1),
        .ofm_port0_v(ofm_port0_v), .ofm_port1_v(ofm_port1_v), .end_conv(end_conv),
        .out_data(out_data), .out_row(out_row), .out_valid(out_valid),
        .out_ready(out_ready), .overflow(overflow), .done(done)
`ifdef OFM_QUANT_STATS_EN
        , .sat_cnt(sat_cnt), .word_cnt(word_cnt)
`endif
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_start(input int sh, input logic relu);
        cfg_shift = 5'(sh);
        cfg_relu  = relu;
        start     = 1'b1;
        tick();
        start     = 1'b0;
    endtask

    task automatic send(input logic v0, input int d0, input logic v1, input int d1);
        ofm_port0_v = v0; ofm_port0 = 25'(d0);
        ofm_port1_v = v1; ofm_port1 = 25'(d1);
        tick();
        ofm_port0_v = 1'b0;
        ofm_port1_v = 1'b0;
    endtask

    task automatic pop_all(output int n, output logic [63:0] first, output logic [63:0] last,
                           output logic last_row);
        n = 0; first = '0; last = '0; last_row = 1'b0;
        out_ready = 1'b1;
        for (int i = 0; i < DEPTH + 4 && out_valid; i++) begin
            if (n == 0) first = out_data;
            last = out_data;
            last_row = out_row;
            n++;
            tick();
        end
        out_ready = 1'b0;
    endtask

    initial begin
        int n, got, dn, early;
        logic [63:0] w0, w1, wl;
        logic r;

        tick(); tick();
        chk("rst_valid", 64'(out_valid), 64'd0);
        chk("rst_data", out_data, 64'd0);
        chk("rst_ovf", 64'(overflow), 64'd0);
        chk("rst_done", 64'(done), 64'd0);
        rst = 1'b0;
        tick();

        // IDLE ignores valids
        for (int k = 0; k < 8; k++) send(1'b1, 16, 1'b1, 16);
        tick(); tick();
        chk("idle_ignore", 64'(out_valid), 64'd0);

        // Basic word, latency
        do_start(4, 1'b0);
        for (int k = 0; k < 8; k++) send(1'b1, k * 16, 1'b0, 0);
        chk("t1_lat_early", 64'(out_valid), 64'd0);
        tick();
        chk("t1_lat", 64'(out_valid), 64'd1);
        chk("t1_data", out_data, 64'h0706050403020100);
        chk("t1_row", 64'(out_row), 64'd0);
        out_ready = 1'b1; tick(); out_ready = 1'b0;
        chk("t1_popped", 64'(out_valid), 64'd0);
`ifdef OFM_QUANT_STATS_EN
        chk("t1_word_cnt", 64'(word_cnt), 64'd1);
`endif

        // Rounding and saturation
        do_start(4, 1'b0);
        send(1'b1, 23, 1'b0, 0);
        send(1'b1, 24, 1'b0, 0);
        send(1'b1, -24, 1'b0, 0);
        send(1'b1, 5000, 1'b0, 0);
        send(1'b1, -5000, 1'b0, 0);
        for (int k = 0; k < 3; k++) send(1'b1, 0, 1'b0, 0);
        tick();
        chk("t2_round_sat", out_data, 64'h000000807FFF0201);
`ifdef OFM_QUANT_STATS_EN
        chk("t2_sat_cnt", 64'(sat_cnt), 64'd2);
`endif
        do_start(4, 1'b1);
        send(1'b1, -5000, 1'b0, 0);
        for (int k = 0; k < 7; k++) send(1'b1, 16, 1'b0, 0);
        tick();
        chk("t2_relu", out_data, 64'h0101010101010100);

        // Both lanes completing together
        do_start(4, 1'b0);
        for (int k = 0; k < 8; k++) send(1'b1, 16, 1'b1, 32);
        tick(); tick();
        chk("t3_w0", out_data, 64'h0101010101010101);
        chk("t3_r0", 64'(out_row), 64'd0);
        out_ready = 1'b1; tick(); out_ready = 1'b0;
        chk("t3_w1", out_data, 64'h0202020202020202);
        chk("t3_r1", 64'(out_row), 64'd1);
        out_ready = 1'b1; tick(); out_ready = 1'b0;
        chk("t3_empty", 64'(out_valid), 64'd0);

        // Overflow on a full FIFO
        do_start(4, 1'b0);
        for (int k = 0; k < 8 * (DEPTH + 1); k++) send(1'b1, (k / 8) * 16, 1'b0, 0);
        tick(); tick();
        chk("t4_ovf", 64'(overflow), 64'd1);
        pop_all(n, w0, wl, r);
        chk("t4_count", 64'(n), 64'(DEPTH));
        chk("t4_first", w0, 64'h0);
        chk("t4_last", wl, 64'h0707070707070707);
        chk("t4_ovf_sticky", 64'(overflow), 64'd1);
        do_start(4, 1'b0);
        chk("t4_start_ovf", 64'(overflow), 64'd0);
        chk("t4_start_valid", 64'(out_valid), 64'd0);

        // One free slot, both lanes complete: port0 kept, port1 dropped
        for (int k = 0; k < 8 * (DEPTH - 1); k++) send(1'b1, 0, 1'b0, 0);
        for (int k = 0; k < 8; k++) send(1'b1, 48, 1'b1, 32);
        tick(); tick();
        chk("t5_ovf", 64'(overflow), 64'd1);
        pop_all(n, w0, wl, r);
        chk("t5_count", 64'(n), 64'(DEPTH));
        chk("t5_last", wl, 64'h0303030303030303);
        chk("t5_last_row", 64'(r), 64'd0);

        // Partial word flush and done
        do_start(4, 1'b0);
        out_ready = 1'b1;
        send(1'b1, 16, 1'b0, 0);
        send(1'b1, 32, 1'b0, 0);
        send(1'b1, 48, 1'b0, 0);
        end_conv = 1'b1; tick(); end_conv = 1'b0;
        got = 0; dn = 0; early = 0; w1 = '0; r = 1'b1;
        for (int i = 0; i < 30; i++) begin
            if (out_valid) begin
                w1 = out_data; r = out_row; got++;
            end
            if (done) begin
                dn++;
                if (got == 0) early++;
            end
            tick();
        end
        out_ready = 1'b0;
        chk("t6_words", 64'(got), 64'd1);
        chk("t6_data", w1, 64'h0000000000030201);
        chk("t6_row", 64'(r), 64'd0);
        chk("t6_done_cnt", 64'(dn), 64'd1);
        chk("t6_done_order", 64'(early), 64'd0);

        // Reset mid-word
        do_start(4, 1'b0);
        for (int k = 0; k < 8; k++) send(1'b1, 16, 1'b0, 0);
        for (int k = 0; k < 5; k++) send(1'b1, 80, 1'b0, 0);
        chk("t7_pre_valid", 64'(out_valid), 64'd1);
        rst = 1'b1;
        #2;
        chk("t7_rst_valid", 64'(out_valid), 64'd0);
        chk("t7_rst_data", out_data, 64'd0);
        rst = 1'b0;
        tick();
        do_start(4, 1'b0);
        for (int k = 0; k < 8; k++) send(1'b1, 32, 1'b0, 0);
        tick();
        chk("t7_clean", out_data, 64'h0202020202020202);
        pop_all(n, w0, wl, r);
        chk("t7_count", 64'(n), 64'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
